// File: rtl/h80cpu_biu_pkg.sv
// rtl/h80cpu_biu_pkg.sv - shared bus types and command encodings for the h80cpu bus
package h80cpu_biu_pkg;

    typedef logic [15:0] bus_addr_t;
    typedef logic [15:0] bus_data_t;

    // Read commands are odd so cmd[0] alone identifies a read.
    typedef enum logic [2:0] {
        CMD_IDLE    = 3'd0,
        CMD_READ_W  = 3'd1,
        CMD_WRITE_W = 3'd2,
        CMD_READ_B  = 3'd3,
        CMD_WRITE_B = 3'd4
    } bus_cmd_t;

    function automatic logic cmd_is_write(input bus_cmd_t c);
        return (c == CMD_WRITE_W) || (c == CMD_WRITE_B);
    endfunction

    function automatic bus_cmd_t cmd_for(input logic wr, input logic byt);
        if (wr) return byt ? CMD_WRITE_B : CMD_WRITE_W;
        return byt ? CMD_READ_B : CMD_READ_W;
    endfunction

endpackage

// File: rtl/h80cpu_biu.sv
// rtl/h80cpu_biu.sv - core-to-bus interface unit: request handshake, split misaligned words, wait timeout
module h80cpu_biu
    import h80cpu_biu_pkg::*;
#(
    parameter int WAIT_MAX = 255
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      req_valid,
    output logic      req_ready,
    input  logic      req_write,
    input  logic      req_byte,
    input  bus_addr_t req_addr,
    input  bus_data_t req_wdata,
    output logic      rsp_valid,
    output bus_data_t rsp_rdata,
    output logic      rsp_err,
    output logic      ce_n,
    output bus_addr_t addr,
    output bus_cmd_t  cmd,
    inout  wire bus_data_t data_,
    input  logic      wait_n
);

    localparam int CNT_W = $clog2(WAIT_MAX + 2);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_MAX);

    typedef enum logic [1:0] {IDLE, RD_ADDR, RD_DATA, WR} state_t;

    state_t           r_state;
    logic             r_ce_n;
    bus_addr_t        r_addr;
    bus_cmd_t         r_cmd;
    logic             r_rsp_valid;
    bus_data_t        r_rsp_rdata;
    logic             r_rsp_err;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_phase;
    logic             r_split;
    logic             r_write;
    logic [7:0]       r_wdata_hi;
    logic [7:0]       r_lo;
    bus_data_t        r_bus_wdata;

    logic w_split_req;
    logic w_timeout;

    assign w_split_req = !req_byte && req_addr[0];
    assign w_timeout   = !wait_n && (r_wait_cnt == CNT_MAX);

    // A pending second half keeps the core out even though the FSM sits in IDLE.
    assign req_ready = (r_state == IDLE) && !r_phase;
    assign ce_n      = r_ce_n;
    assign addr      = r_addr;
    assign cmd       = r_cmd;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign data_     = (!r_ce_n && cmd_is_write(r_cmd)) ? r_bus_wdata : 'z;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_ce_n      <= 1'b1;
            r_addr      <= '0;
            r_cmd       <= CMD_IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_wait_cnt  <= '0;
            r_phase     <= 1'b0;
            r_split     <= 1'b0;
            r_write     <= 1'b0;
            r_wdata_hi  <= '0;
            r_lo        <= '0;
            r_bus_wdata <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            if (r_state == IDLE) begin
                r_wait_cnt <= '0;
                if (r_phase) begin
                    r_state     <= r_write ? WR : RD_ADDR;
                    r_ce_n      <= 1'b0;
                    r_addr      <= r_addr + 16'd1;
                    r_cmd       <= cmd_for(r_write, 1'b1);
                    r_bus_wdata <= {8'h00, r_wdata_hi};
                end else if (req_valid) begin
                    r_state     <= req_write ? WR : RD_ADDR;
                    r_ce_n      <= 1'b0;
                    r_addr      <= req_addr;
                    r_cmd       <= cmd_for(req_write, req_byte || w_split_req);
                    r_write     <= req_write;
                    r_split     <= w_split_req;
                    r_wdata_hi  <= req_wdata[15:8];
                    r_bus_wdata <= (req_byte || w_split_req) ? {8'h00, req_wdata[7:0]} : req_wdata;
                end
            end else if (w_timeout) begin
                r_state     <= IDLE;
                r_ce_n      <= 1'b1;
                r_cmd       <= CMD_IDLE;
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= 1'b1;
                r_rsp_rdata <= '0;
                r_phase     <= 1'b0;
                r_wait_cnt  <= '0;
            end else if (!wait_n) begin
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            end else begin
                r_wait_cnt <= '0;
                if (r_state == RD_ADDR) begin
                    r_state <= RD_DATA;
                end else begin
                    r_state <= IDLE;
                    r_ce_n  <= 1'b1;
                    r_cmd   <= CMD_IDLE;
                    if (r_split && !r_phase) begin
                        r_phase <= 1'b1;
                        r_lo    <= data_[7:0];
                    end else begin
                        r_phase     <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        if (r_state == RD_DATA) begin
                            if (r_split)
                                r_rsp_rdata <= {data_[7:0], r_lo};
                            else if (r_cmd == CMD_READ_B)
                                r_rsp_rdata <= {8'h00, data_[7:0]};
                            else
                                r_rsp_rdata <= data_;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_h80cpu_biu.sv
// tb/tb_h80cpu_biu.sv - self-checking bench for h80cpu_biu with a byte-memory bus model
module tb_h80cpu_biu;
    import h80cpu_biu_pkg::*;

    localparam int WAIT_MAX = 4;

    logic      clk = 1'b0;
    logic      reset = 1'b1;
    logic      req_valid = 1'b0;
    logic      req_write = 1'b0;
    logic      req_byte = 1'b0;
    bus_addr_t req_addr = '0;
    bus_data_t req_wdata = '0;
    logic      wait_n = 1'b1;
    logic      req_ready;
    logic      rsp_valid;
    bus_data_t rsp_rdata;
    logic      rsp_err;
    logic      ce_n;
    bus_addr_t addr;
    bus_cmd_t  cmd;
    wire bus_data_t data_;

    h80cpu_biu #(.WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ce_n(ce_n), .addr(addr), .cmd(cmd), .data_(data_), .wait_n(wait_n)
    );

    always #5 clk = ~clk;

    // Bus-side memory; byte reads put junk on the upper lane to exercise zero-extension.
    logic [7:0] bus_mem [0:65535];
    logic [7:0] ref_mem [0:65535];
    bus_addr_t  addr_p1;
    bus_data_t  bus_rd;

    always_comb begin
        addr_p1 = addr + 16'd1;
        bus_rd  = (cmd == CMD_READ_B) ? {8'hC3, bus_mem[addr]} : {bus_mem[addr_p1], bus_mem[addr]};
    end
    assign data_ = (!ce_n && cmd[0]) ? bus_rd : 'z;

    always @(posedge clk) begin
        if (!ce_n && wait_n) begin
            if (cmd == CMD_WRITE_B || cmd == CMD_WRITE_W) bus_mem[addr] <= data_[7:0];
            if (cmd == CMD_WRITE_W) bus_mem[addr_p1] <= data_[15:8];
        end
    end

    initial begin
        for (int i = 0; i < 65536; i++) bus_mem[i] <= 8'h00;
    end

    int wait_mode = 0;
    int wait_left = 0;
    int low_run = 0;
    always @(negedge clk) begin
        case (wait_mode)
            0: wait_n = 1'b1;
            1: begin
                if (low_run < 2 && $urandom_range(0, 3) == 0) begin
                    wait_n = 1'b0;
                    low_run++;
                end else begin
                    wait_n = 1'b1;
                    low_run = 0;
                end
            end
            2: wait_n = 1'b0;
            default: begin
                if (!ce_n && wait_left > 0) begin
                    wait_n = 1'b0;
                    wait_left--;
                end else begin
                    wait_n = 1'b1;
                end
            end
        endcase
    end

    int n_tests = 0;
    int n_fail = 0;
    logic [19:0] bus_log[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic ref_write(input bus_addr_t a, input logic byt, input bus_data_t wd);
        bus_addr_t a1;
        a1 = a + 16'd1;
        ref_mem[a] = wd[7:0];
        if (!byt) ref_mem[a1] = wd[15:8];
    endtask

    function automatic bus_data_t ref_read(input bus_addr_t a, input logic byt);
        bus_addr_t a1;
        a1 = a + 16'd1;
        return byt ? {8'h00, ref_mem[a]} : {ref_mem[a1], ref_mem[a]};
    endfunction

    // cyc is the cycle (after the accepting edge) in which rsp_valid is seen.
    task automatic do_access(input logic wr, input logic byt, input bus_addr_t a, input bus_data_t wd,
                             output bus_data_t rd, output logic err, output int cyc, output int lows);
        int guard;
        bus_log.delete();
        @(negedge clk);
        req_valid = 1'b1;
        req_write = wr;
        req_byte  = byt;
        req_addr  = a;
        req_wdata = wd;
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) check("req_ready_wait", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        cyc  = 1;
        lows = 0;
        while (!rsp_valid && cyc < 100) begin
            bus_log.push_back({ce_n, cmd, addr});
            if (!ce_n) lows++;
            @(negedge clk);
            cyc++;
        end
        if (!rsp_valid) check("rsp_valid_timeout", 32'(rsp_valid), 32'd1);
        rd  = rsp_rdata;
        err = rsp_err;
    endtask

    typedef struct {
        logic      wr;
        logic      byt;
        bus_addr_t a;
        bus_data_t wd;
        bus_data_t exp_rd;
        int        exp_lat;
        int        exp_lows;
    } vec_t;

    vec_t vecs[13];

    initial begin
        bus_data_t rd;
        logic      err;
        int        cyc;
        int        lows;

        for (int i = 0; i < 65536; i++) ref_mem[i] = 8'h00;

        vecs[0]  = '{1'b1, 1'b0, 16'h0010, 16'hBEEF, 16'h0000, 2, 1};
        vecs[1]  = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 3, 2};
        vecs[2]  = '{1'b1, 1'b0, 16'h0020, 16'h1234, 16'h0000, 2, 1};
        vecs[3]  = '{1'b1, 1'b1, 16'h0021, 16'h005A, 16'h0000, 2, 1};
        vecs[4]  = '{1'b0, 1'b0, 16'h0020, 16'h0000, 16'h5A34, 3, 2};
        vecs[5]  = '{1'b1, 1'b0, 16'hFFFF, 16'hA1B2, 16'h0000, 4, 2};
        vecs[6]  = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'hA1B2, 6, 4};
        vecs[7]  = '{1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'h00B2, 3, 2};
        vecs[8]  = '{1'b0, 1'b1, 16'h0000, 16'h0000, 16'h00A1, 3, 2};
        vecs[9]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h00A1, 3, 2};
        vecs[10] = '{1'b1, 1'b1, 16'h0011, 16'h0077, 16'h0000, 2, 1};
        vecs[11] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'h77EF, 3, 2};
        vecs[12] = '{1'b0, 1'b0, 16'h0011, 16'h0000, 16'h0077, 6, 4};

        repeat (3) @(negedge clk);
        check("rst_ce_n", 32'(ce_n), 32'd1);
        check("rst_cmd", 32'(cmd), 32'd0);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_req_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < 13; i++) begin
            do_access(vecs[i].wr, vecs[i].byt, vecs[i].a, vecs[i].wd, rd, err, cyc, lows);
            if (!vecs[i].wr) check($sformatf("vec%0d_rdata", i), 32'(rd), 32'(vecs[i].exp_rd));
            else ref_write(vecs[i].a, vecs[i].byt, vecs[i].wd);
            check($sformatf("vec%0d_err", i), 32'(err), 32'd0);
            check($sformatf("vec%0d_latency", i), 32'(cyc), 32'(vecs[i].exp_lat));
            check($sformatf("vec%0d_ce_low_cycles", i), 32'(lows), 32'(vecs[i].exp_lows));
            if (i == 1) begin
                check("rd0010_log_len", 32'(bus_log.size()), 32'd2);
                for (int k = 0; k < bus_log.size(); k++)
                    check($sformatf("rd0010_bus%0d", k), 32'(bus_log[k]), 32'({1'b0, 3'd1, 16'h0010}));
            end
            if (i == 5) begin
                check("split_wr_log_len", 32'(bus_log.size()), 32'd3);
                if (bus_log.size() == 3) begin
                    check("split_wr_first", 32'(bus_log[0]), 32'({1'b0, 3'd4, 16'hFFFF}));
                    check("split_wr_gap", 32'(bus_log[1]), 32'({1'b1, 3'd0, 16'hFFFF}));
                    check("split_wr_second", 32'(bus_log[2]), 32'({1'b0, 3'd4, 16'h0000}));
                end
            end
        end

        // Three wait cycles in RD_ADDR stretch the read by exactly three cycles.
        wait_mode = 3;
        wait_left = 3;
        do_access(1'b0, 1'b0, 16'h0010, 16'h0000, rd, err, cyc, lows);
        check("wait3_rdata", 32'(rd), 32'h77EF);
        check("wait3_latency", 32'(cyc), 32'd6);
        for (int k = 0; k < bus_log.size(); k++)
            if (!bus_log[k][19])
                check($sformatf("wait3_bus%0d", k), 32'(bus_log[k]), 32'({1'b0, 3'd1, 16'h0010}));
        wait_mode = 0;

        // Stuck wait_n: abort after the fifth consecutive wait cycle.
        wait_mode = 2;
        do_access(1'b0, 1'b0, 16'h0020, 16'h0000, rd, err, cyc, lows);
        check("timeout_err", 32'(err), 32'd1);
        check("timeout_rdata", 32'(rd), 32'd0);
        check("timeout_latency", 32'(cyc), 32'd6);
        @(negedge clk);
        check("timeout_req_ready", 32'(req_ready), 32'd1);
        check("timeout_ce_n", 32'(ce_n), 32'd1);
        check("timeout_cmd", 32'(cmd), 32'd0);
        wait_mode = 0;
        do_access(1'b0, 1'b0, 16'h0020, 16'h0000, rd, err, cyc, lows);
        check("post_timeout_rdata", 32'(rd), 32'h5A34);
        check("post_timeout_err", 32'(err), 32'd0);

        // Reset while in RD_DATA abandons the read silently.
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_byte  = 1'b0;
        req_addr  = 16'h0020;
        @(negedge clk);
        req_valid = 1'b0;
        check("mid_rst_pre_ce_n", 32'(ce_n), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_ce_n", 32'(ce_n), 32'd1);
        check("mid_rst_cmd", 32'(cmd), 32'd0);
        check("mid_rst_addr", 32'(addr), 32'd0);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_rdata", 32'(rsp_rdata), 32'd0);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("mid_rst_no_rsp", 32'(rsp_valid), 32'd0);
        end

        // Random traffic around the address wrap with random short stalls.
        wait_mode = 1;
        for (int n = 0; n < 300; n++) begin
            logic      wr;
            logic      byt;
            bus_addr_t a;
            bus_data_t wd;
            int        r;
            wr  = 1'($urandom_range(0, 1));
            byt = 1'($urandom_range(0, 1));
            r   = $urandom_range(0, 15);
            a   = (r < 8) ? 16'(r) : 16'(16'hFFF8 + 16'(r - 8));
            wd  = 16'($urandom);
            do_access(wr, byt, a, wd, rd, err, cyc, lows);
            if (wr) ref_write(a, byt, wd);
            else check($sformatf("rand%0d_rdata", n), 32'(rd), 32'(ref_read(a, byt)));
            check($sformatf("rand%0d_err", n), 32'(err), 32'd0);
        end
        wait_mode = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule
